scope_trigger_capture: RTL and testbench

//  Acquisition stage directly upstream of the HDMI display controller's val/readValEn input.

---
 rtl/scope_trigger_capture_if.sv | 13 +
 rtl/scope_trigger_capture.sv | 140 ++++++++++++++
 tb/tb_scope_trigger_capture.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/scope_trigger_capture_if.sv
// Frame output stream toward the display controller: one sample per column with
// valid/ready handshake and a start-of-frame marker.
interface scope_trigger_capture_if #(
  parameter int VAL_RES = 12
);
  logic [VAL_RES-1:0] val;
  logic               val_valid;
  logic               val_ready;
  logic               frame_first;

  modport master (output val, output val_valid, output frame_first, input val_ready);
  modport slave  (input val, input val_valid, input frame_first, output val_ready);
endinterface

// File: rtl/scope_trigger_capture.sv
// Triggered scope acquisition: ring-buffers an ADC stream around a level-crossing
// trigger, then drains one DEPTH-sample frame in address order over valid/ready.
module scope_trigger_capture #(
  parameter int VAL_RES = 12,
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int PRETRIG = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [VAL_RES-1:0] i_adc_val,
  input  logic               i_adc_valid,
  input  logic [VAL_RES-1:0] i_trig_level,
  input  logic               i_trig_fall,
  input  logic               i_arm,
  output logic               o_busy,
  scope_trigger_capture_if.master m_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_WAIT_TRIG, S_POSTFILL, S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W-1:0] RD_OFF    = ADDR_W'(DEPTH - PRETRIG);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   XFER_LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t r_state, w_next;

  logic [VAL_RES-1:0] r_buf [DEPTH];
  logic [VAL_RES-1:0] r_level, r_prev, r_val;
  logic               r_fall, r_val_valid, r_first;
  logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr, r_cnt;
  logic [ADDR_W:0]    r_issued, r_xfer;

  logic              w_write, w_hit, w_rise, w_fallhit, w_load, w_xfer;
  logic [ADDR_W-1:0] w_start;

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_A) ? '0 : p + 1'b1;
  endfunction

  assign w_write   = i_adc_valid &&
                     (r_state == S_PREFILL || r_state == S_WAIT_TRIG || r_state == S_POSTFILL);
  assign w_rise    = (r_prev < r_level) && (i_adc_val >= r_level);
  assign w_fallhit = (r_prev > r_level) && (i_adc_val <= r_level);
  assign w_hit     = (r_state == S_WAIT_TRIG) && i_adc_valid && (r_fall ? w_fallhit : w_rise);
  // Frame start is PRETRIG slots behind the trigger address, wrapped into [0, DEPTH).
  assign w_start   = (r_wr_ptr >= PRE_A) ? (r_wr_ptr - PRE_A) : (r_wr_ptr + RD_OFF);
  assign w_xfer    = r_val_valid && m_out.val_ready;
  assign w_load    = (r_state == S_DRAIN) && (!r_val_valid || m_out.val_ready) &&
                     (r_issued != DEPTH_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_arm) w_next = S_PREFILL;
      S_PREFILL:   if (i_adc_valid && r_cnt == PRE_LAST) w_next = S_WAIT_TRIG;
      S_WAIT_TRIG: if (w_hit) w_next = (DEPTH - PRETRIG == 1) ? S_DRAIN : S_POSTFILL;
      S_POSTFILL:  if (i_adc_valid && r_cnt == POST_LAST) w_next = S_DRAIN;
      S_DRAIN:     if (w_xfer && r_xfer == XFER_LAST) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_write) r_buf[r_wr_ptr] <= i_adc_val;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level     <= '0;
      r_fall      <= 1'b0;
      r_prev      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_issued    <= '0;
      r_xfer      <= '0;
      r_val       <= '0;
      r_val_valid <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_arm) begin
            r_level  <= i_trig_level;
            r_fall   <= i_trig_fall;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_issued <= '0;
            r_xfer   <= '0;
          end
        end
        S_PREFILL, S_WAIT_TRIG, S_POSTFILL: begin
          if (i_adc_valid) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
            r_prev   <= i_adc_val;
            if (w_hit) begin
              r_cnt    <= ADDR_W'(1);
              r_rd_ptr <= w_start;
            end else if (r_state != S_WAIT_TRIG) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Registered skid: refill whenever the slot is empty or being taken.
          if (w_load) begin
            r_val       <= r_buf[r_rd_ptr];
            r_val_valid <= 1'b1;
            r_first     <= (r_issued == '0);
            r_rd_ptr    <= next_ptr(r_rd_ptr);
            r_issued    <= r_issued + 1'b1;
          end else if (w_xfer) begin
            r_val_valid <= 1'b0;
            r_first     <= 1'b0;
          end
          if (w_xfer) r_xfer <= r_xfer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy            = (r_state != S_IDLE);
  assign m_out.val         = r_val;
  assign m_out.val_valid   = r_val_valid;
  assign m_out.frame_first = r_first;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture with DEPTH=16, PRETRIG=4: ramp-driven
// capture scenarios from a vector table plus reset and no-trigger sequences.
module tb_scope_trigger_capture;
  localparam int VR    = 12;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PRE   = 4;
  localparam int MAXC  = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic [VR-1:0] adc_val;
  logic          adc_valid;
  logic [VR-1:0] trig_level;
  logic          trig_fall;
  logic          arm;
  logic          busy;

  scope_trigger_capture_if #(.VAL_RES(VR)) u_if ();

  scope_trigger_capture #(
    .VAL_RES(VR), .DEPTH(DEPTH), .ADDR_W(AW), .PRETRIG(PRE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_adc_val(adc_val), .i_adc_valid(adc_valid),
    .i_trig_level(trig_level), .i_trig_fall(trig_fall), .i_arm(arm),
    .o_busy(busy), .m_out(u_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fall;
    int level;
    int start;
    int step;
    int hold;       // leading zero samples before the ramp starts
    bit bp;         // val_ready follows 1,0,0,1
    int arm_k;      // sample index at which a stray arm (level 30) is pulsed, -1 none
    bit arm_last;   // stray arm in the cycle of the final transfer
    int exp_first;
    int exp_step;
  } vec_t;

  vec_t tbl[7];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   pat[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VR-1:0] smp(input vec_t v, input int k);
    return (k < v.hold) ? '0 : VR'(v.start + v.step * (k - v.hold));
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int            k, n;
    bit            stalled, done;
    logic [VR-1:0] sv, ev;
    logic          sf;
    @(posedge clk); #1;
    trig_level = VR'(v.level);
    trig_fall  = v.fall;
    adc_valid  = 1'b0;
    arm        = 1'b1;
    @(posedge clk); #1;
    arm     = 1'b0;
    k       = 0;
    n       = 0;
    stalled = 1'b0;
    done    = 1'b0;
    sv      = '0;
    sf      = 1'b0;
    for (int cyc = 0; cyc < MAXC && !done; cyc++) begin
      adc_val        = smp(v, k);
      adc_valid      = 1'b1;
      u_if.val_ready = v.bp ? pat[cyc % 4] : 1'b1;
      if (k == v.arm_k) begin
        arm        = 1'b1;
        trig_level = VR'(30);
      end else begin
        arm = 1'b0;
      end
      k++;
      @(negedge clk);
      if (stalled) begin
        chk($sformatf("v%0d hold_valid", id), 32'(u_if.val_valid), 32'd1);
        chk($sformatf("v%0d hold_val", id), 32'(u_if.val), 32'(sv));
        chk($sformatf("v%0d hold_first", id), 32'(u_if.frame_first), 32'(sf));
      end
      stalled = u_if.val_valid && !u_if.val_ready;
      sv      = u_if.val;
      sf      = u_if.frame_first;
      if (u_if.val_valid && u_if.val_ready) begin
        ev = VR'(v.exp_first + v.exp_step * n);
        chk($sformatf("v%0d val[%0d]", id, n), 32'(u_if.val), 32'(ev));
        chk($sformatf("v%0d first[%0d]", id, n), 32'(u_if.frame_first), 32'(n == 0));
        n++;
        if (n == DEPTH) begin
          done = 1'b1;
          if (v.arm_last) begin
            arm        = 1'b1;
            trig_level = VR'(30);
          end
        end
      end
      @(posedge clk); #1;
    end
    arm = 1'b0;
    chk($sformatf("v%0d transfers", id), 32'(n), 32'(DEPTH));
    chk($sformatf("v%0d end_busy", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d end_valid", id), 32'(u_if.val_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_after", id), 32'(busy), 32'd0);
  endtask

  initial begin
    bit found;
    //          fall lvl start step hold bp armk last first step
    tbl[0] = '{1'b0, 100,   0,  10,   0, 1'b0, -1, 1'b0, 60,  10};
    tbl[1] = '{1'b1,  50, 200, -10,   0, 1'b0, -1, 1'b0, 90, -10};
    tbl[2] = '{1'b0, 100,   0,  10,  55, 1'b0, -1, 1'b0, 60,  10};
    tbl[3] = '{1'b0, 100,   0,  10,   0, 1'b1, -1, 1'b0, 60,  10};
    tbl[4] = '{1'b0, 100,   0,  10,   0, 1'b0,  1, 1'b1, 60,  10};
    tbl[5] = '{1'b0,  95,   0,  10,   0, 1'b0, -1, 1'b0, 60,  10};
    tbl[6] = '{1'b1,  55, 200, -10,   0, 1'b1, -1, 1'b0, 90, -10};

    rst            = 1'b1;
    adc_val        = '0;
    adc_valid      = 1'b0;
    trig_level     = '0;
    trig_fall      = 1'b0;
    arm            = 1'b0;
    u_if.val_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst val_valid", 32'(u_if.val_valid), 32'd0);
    chk("rst val", 32'(u_if.val), 32'd0);
    chk("rst frame_first", 32'(u_if.frame_first), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Input parked at the level never crosses it; then force a crossing and reset mid-drain.
    @(posedge clk); #1;
    trig_level = VR'(100);
    trig_fall  = 1'b0;
    arm        = 1'b1;
    @(posedge clk); #1;
    arm       = 1'b0;
    adc_valid = 1'b1;
    adc_val   = VR'(100);
    repeat (40) @(posedge clk);
    #1;
    chk("flat busy", 32'(busy), 32'd1);
    chk("flat val_valid", 32'(u_if.val_valid), 32'd0);
    adc_val = VR'(0);
    @(posedge clk); #1;
    adc_val = VR'(200);
    found   = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (u_if.val_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("flat drain_reached", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst val_valid", 32'(u_if.val_valid), 32'd0);
    chk("midrst val", 32'(u_if.val), 32'd0);
    chk("midrst frame_first", 32'(u_if.frame_first), 32'd0);

    run_vec(tbl[0], 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
